// File: rtl/seq_pattern_detector.sv
// Serial 8-bit sliding-window pattern detector with keypad-programmed pattern.
// Define SEQ_DET_OVERLAP_EN to report overlapping occurrences.
module seq_pattern_detector #(
  parameter int BIT_PERIOD  = 100000000,
  parameter int BEEP_CYCLES = 50000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] key_code,
  input  logic       key_stb,
  input  logic       din,
  output logic [7:0] pattern,
  output logic [7:0] led,
  output logic       match,
  output logic [3:0] hit_cnt,
  output logic       armed,
  output logic       buzzer
);

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    DETECT
  } state_t;

`ifdef SEQ_DET_OVERLAP_EN
  localparam bit OVERLAP = 1'b1;
`else
  localparam bit OVERLAP = 1'b0;
`endif

  localparam int TW = $clog2(BIT_PERIOD);
  localparam int BW = $clog2(BEEP_CYCLES + 1);
  localparam logic [TW-1:0] TICK_AT = TW'(BIT_PERIOD / 2 - 1);
  localparam logic [TW-1:0] T_LAST  = TW'(BIT_PERIOD - 1);
  localparam logic [BW-1:0] BEEP_LD = BW'(BEEP_CYCLES);

  localparam logic [4:0] K_MUTE = 5'd13;
  localparam logic [4:0] K_ARM  = 5'd14;
  localparam logic [4:0] K_CLR  = 5'd15;

  state_t state_q;
  state_t state_d;

  logic          din_m;
  logic          din_s;
  logic [TW-1:0] tcnt;
  logic [7:0]    pat_q;
  logic [7:0]    led_q;
  logic [3:0]    hit_q;
  logic [3:0]    bcnt_q;
  logic [BW-1:0] beep_q;
  logic          match_q;

  logic       tick;
  logic       key_set;
  logic       key_arm;
  logic       key_clr;
  logic       key_mute;
  logic       shift;
  logic       hit;
  logic [7:0] win_nxt;
  logic [7:0] set_mask;

  assign tick     = (tcnt == TICK_AT);
  assign key_arm  = key_stb && (key_code == K_ARM);
  assign key_clr  = key_stb && (key_code == K_CLR);
  assign key_mute = key_stb && (key_code == K_MUTE);
  assign key_set  = key_stb && (state_q == IDLE) &&
                    (key_code >= 5'd1) && (key_code <= 5'd8);
  assign set_mask = 8'(1) << (key_code - 5'd1);
  assign win_nxt  = {led_q[6:0], din_s};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      din_m <= 1'b0;
      din_s <= 1'b0;
    end else begin
      din_m <= din;
      din_s <= din_m;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tcnt <= '0;
    end else if (key_arm) begin
      tcnt <= '0;
    end else if (tcnt == T_LAST) begin
      tcnt <= '0;
    end else begin
      tcnt <= tcnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Key actions win over a coincident tick.
  always_comb begin
    state_d = state_q;
    shift   = 1'b0;
    hit     = 1'b0;
    unique case (1'b1)
      key_clr: state_d = IDLE;
      key_arm: state_d = ARMED;
      default: begin
        if (tick) begin
          unique case (state_q)
            IDLE: ;
            ARMED: begin
              shift = 1'b1;
              if (bcnt_q == 4'd7) begin
                state_d = DETECT;
                hit     = (win_nxt == pat_q);
              end
            end
            DETECT: begin
              shift = 1'b1;
              hit   = (win_nxt == pat_q);
            end
            default: state_d = IDLE;
          endcase
          if (hit && !OVERLAP) begin
            state_d = ARMED;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pat_q <= '0;
    end else if (key_clr) begin
      pat_q <= '0;
    end else if (key_set) begin
      pat_q <= pat_q | set_mask;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led_q  <= '0;
      bcnt_q <= '0;
    end else if (key_clr || key_arm) begin
      led_q  <= '0;
      bcnt_q <= '0;
    end else if (shift) begin
      led_q <= win_nxt;
      if (hit && !OVERLAP) begin
        bcnt_q <= '0;
      end else if (state_q == ARMED) begin
        bcnt_q <= bcnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_q   <= '0;
      match_q <= 1'b0;
    end else begin
      match_q <= hit;
      if (key_clr) begin
        hit_q <= '0;
      end else if (hit && (hit_q != 4'hf)) begin
        hit_q <= hit_q + 1'b1;
      end
    end
  end

  // A match in the same cycle as mute still restarts the beep.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beep_q <= '0;
    end else if (hit) begin
      beep_q <= BEEP_LD;
    end else if (key_clr || key_mute) begin
      beep_q <= '0;
    end else if (beep_q != '0) begin
      beep_q <= beep_q - 1'b1;
    end
  end

  assign pattern = pat_q;
  assign led     = led_q;
  assign match   = match_q;
  assign hit_cnt = hit_q;
  assign armed   = (state_q != IDLE);
  assign buzzer  = (beep_q != '0);

endmodule

// File: tb/tb_seq_pattern_detector.sv
// Bench for seq_pattern_detector: directed and random bit streams
// against a bit-level reference of the detection rules.
module tb_seq_pattern_detector;

  localparam int BP   = 4;
  localparam int BEEP = 10;
`ifdef SEQ_DET_OVERLAP_EN
  localparam bit OVL = 1'b1;
`else
  localparam bit OVL = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] key_code;
  logic       key_stb;
  logic       din;
  logic [7:0] pattern;
  logic [7:0] led;
  logic       match;
  logic [3:0] hit_cnt;
  logic       armed;
  logic       buzzer;

  int errors = 0;
  int checks = 0;

  logic [7:0] m_pat;
  logic [7:0] m_win;
  int         m_nbits;
  int         m_age;
  int         m_beep;
  int         m_hits;
  bit         m_armed;
  bit         m_match;

  seq_pattern_detector #(
    .BIT_PERIOD (BP),
    .BEEP_CYCLES(BEEP)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .key_code(key_code),
    .key_stb (key_stb),
    .din     (din),
    .pattern (pattern),
    .led     (led),
    .match   (match),
    .hit_cnt (hit_cnt),
    .armed   (armed),
    .buzzer  (buzzer)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pat   = '0;
    m_win   = '0;
    m_nbits = 0;
    m_age   = 0;
    m_beep  = 0;
    m_hits  = 0;
    m_armed = 0;
    m_match = 0;
  endtask

  // Bits are sampled mid-bit: 2, 6, 10 ... cycles after the arm strobe.
  task automatic model_edge();
    bit is_arm, is_clr, is_mute;
    if (!rst_n) begin
      model_reset();
      return;
    end
    is_arm  = key_stb && key_code == 5'd14;
    is_clr  = key_stb && key_code == 5'd15;
    is_mute = key_stb && key_code == 5'd13;
    m_match = 0;
    m_age++;
    if (key_stb && key_code >= 1 && key_code <= 8 && !m_armed)
      m_pat[key_code - 1] = 1'b1;
    if (is_clr) begin
      m_armed = 0;
      m_pat   = '0;
      m_win   = '0;
      m_hits  = 0;
      m_nbits = 0;
    end else if (is_arm) begin
      m_armed = 1;
      m_win   = '0;
      m_nbits = 0;
      m_age   = 0;
    end else if (m_armed && (m_age % BP) == BP / 2) begin
      m_win = {m_win[6:0], din};
      m_nbits++;
      if (m_nbits >= 8 && m_win == m_pat) begin
        m_match = 1;
        if (m_hits < 15) m_hits++;
        if (!OVL) m_nbits = 0;
      end
    end
    if (m_match) m_beep = BEEP;
    else if (is_clr || is_mute) m_beep = 0;
    else if (m_beep > 0) m_beep--;
  endtask

  task automatic check_all();
    chk("pattern", pattern, m_pat);
    chk("led", led, m_win);
    chk("match", {7'b0, match}, {7'b0, m_match});
    chk("hit_cnt", {4'b0, hit_cnt}, 8'(m_hits));
    chk("armed", {7'b0, armed}, {7'b0, m_armed});
    chk("buzzer", {7'b0, buzzer}, {7'b0, m_beep > 0});
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      model_edge();
      @(negedge clk);
      check_all();
    end
  endtask

  task automatic press(input logic [4:0] code);
    key_code = code;
    key_stb  = 1'b1;
    step(1);
    key_stb  = 1'b0;
    key_code = 5'd17;
  endtask

  // First bit must be stable before the arm edge to reach the synchroniser.
  task automatic arm_with(input logic b0);
    din = b0;
    press(5'd14);
    step(2);
  endtask

  task automatic send_bit(input logic b, input logic [4:0] kc);
    int k;
    din = b;
    if (kc == 0) begin
      step(4);
    end else begin
      k = $urandom_range(0, 3);
      step(k);
      press(kc);
      step(3 - k);
    end
  endtask

  task automatic set_keys(input logic [7:0] p);
    for (int i = 0; i < 8; i++)
      if (p[i]) press(5'(i + 1));
  endtask

  initial begin
    logic [7:0] p;
    logic [7:0] v85;
    logic [4:0] codes [14];
    logic [4:0] kc;
    logic       b;

    for (int i = 0; i < 13; i++) codes[i] = 5'(i + 1);
    codes[13] = 5'd16;

    rst_n    = 1'b0;
    din      = 1'b0;
    key_stb  = 1'b0;
    key_code = 5'd17;
    model_reset();
    #1;
    check_all();
    step(2);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      din = ~din;
      step(1);
    end
    chk("idle_led", led, 8'h00);

    set_keys(8'h85);
    chk("pat_85", pattern, 8'h85);
    v85 = 8'h85;
    arm_with(v85[7]);
    for (int i = 6; i >= 0; i--) send_bit(v85[i], 5'd0);
    chk("hit_85", {4'b0, hit_cnt}, 8'd1);
    step(12);

    press(5'd15);
    arm_with(1'b0);
    for (int i = 0; i < 10; i++) send_bit(1'b0, 5'd0);
    chk("zeros_hits", {4'b0, hit_cnt}, OVL ? 8'd4 : 8'd1);
    press(5'd13);
    chk("mute_buz", {7'b0, buzzer}, 8'd0);
    chk("mute_hits", {4'b0, hit_cnt}, OVL ? 8'd4 : 8'd1);
    step(3);

    press(5'd15);
    p = 8'($urandom_range(1, 255));
    set_keys(p);
    arm_with(p[7]);
    for (int i = 6; i >= 0; i--) send_bit(p[i], 5'd0);
    for (int r = 0; r < 16; r++)
      for (int i = 7; i >= 0; i--) send_bit(p[i], 5'd0);
    chk("sat_hits", {4'b0, hit_cnt}, 8'd15);
    press(5'd2);
    chk("armed_key_pat", pattern, p);
    press(5'd15);
    chk("clr_pat", pattern, 8'h00);
    chk("clr_led", led, 8'h00);
    chk("clr_hits", {4'b0, hit_cnt}, 8'd0);
    chk("clr_armed", {7'b0, armed}, 8'd0);

    for (int r = 0; r < 4; r++) begin
      press(5'd15);
      press(5'd9);
      press(5'd16);
      for (int j = 0; j < 3; j++) press(5'($urandom_range(1, 8)));
      p = m_pat;
      arm_with(p[7]);
      for (int i = 1; i < 48; i++) begin
        b  = ($urandom_range(0, 1) == 1) ? p[7 - (i % 8)]
                                         : 1'($urandom_range(0, 1));
        kc = ($urandom_range(0, 5) == 0) ? codes[$urandom_range(0, 13)]
                                         : 5'd0;
        send_bit(b, kc);
      end
      step(3);
    end

    press(5'd15);
    arm_with(1'b0);
    for (int i = 0; i < 7; i++) send_bit(1'b0, 5'd0);
    step(1);
    chk("pre_rst_buz", {7'b0, buzzer}, 8'd1);
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("rst_buz", {7'b0, buzzer}, 8'd0);
    chk("rst_hits", {4'b0, hit_cnt}, 8'd0);
    chk("rst_armed", {7'b0, armed}, 8'd0);
    chk("rst_match", {7'b0, match}, 8'd0);
    check_all();
    @(negedge clk);
    step(2);
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      din = ~din;
      step(1);
    end
    chk("post_rst_led", led, 8'h00);
    chk("post_rst_armed", {7'b0, armed}, 8'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
